// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises the optical gate, measures each blocked
// pulse and emits a one-cycle coin code or reject pulse.
`timescale 1ns/1ps
module coin_acceptor #(
  parameter int CNT_W      = 8,
  parameter int GLITCH_MAX = 1,
  parameter int N_MIN      = 4,
  parameter int N_MAX      = 8,
  parameter int D_MIN      = 12,
  parameter int D_MAX      = 20,
  parameter int STUCK      = 60,
  parameter int GAP        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_in,
  input  logic       enable,
  output logic [1:0] coin,
  output logic       reject
);

  localparam logic [1:0] ARM  = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;
  localparam logic [1:0] JAM  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_MAX);
  localparam logic [CNT_W-1:0] N_MIN_C  = CNT_W'(N_MIN);
  localparam logic [CNT_W-1:0] N_MAX_C  = CNT_W'(N_MAX);
  localparam logic [CNT_W-1:0] D_MIN_C  = CNT_W'(D_MIN);
  localparam logic [CNT_W-1:0] D_MAX_C  = CNT_W'(D_MAX);
  localparam logic [CNT_W-1:0] STUCK_C  = CNT_W'(STUCK);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP);

  logic             sync1_r;
  logic             s_r;
  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] width_r;
  logic [CNT_W-1:0] width_s;
  logic [CNT_W-1:0] gap_r;
  logic [CNT_W-1:0] gap_s;
  logic [CNT_W-1:0] width_inc_s;
  logic [CNT_W-1:0] gap_inc_s;
  logic [1:0]       coin_s;
  logic             reject_s;
  logic [2:0]       class_s;

  // Returns {coin[1:0], reject} for a finished pulse of width w.
  function automatic logic [2:0] classify(input logic [CNT_W-1:0] w, input logic en);
    logic [2:0] res;
    if (w <= GLITCH_C) begin
      res = 3'b000;
    end else if (w >= N_MIN_C && w <= N_MAX_C) begin
      res = en ? 3'b010 : 3'b001;
    end else if (w >= D_MIN_C && w <= D_MAX_C) begin
      res = en ? 3'b100 : 3'b001;
    end else begin
      res = 3'b001;
    end
    return res;
  endfunction

  // Next-state, counter and output decode.
  always_comb begin
    state_s     = state_r;
    width_s     = width_r;
    gap_s       = gap_r;
    coin_s      = 2'b00;
    reject_s    = 1'b0;
    width_inc_s = (width_r == CNT_MAX) ? width_r : width_r + CNT_ONE;
    gap_inc_s   = (gap_r == CNT_MAX) ? gap_r : gap_r + CNT_ONE;
    class_s     = classify(width_r, enable);
    case (state_r)
      ARM: begin
        if (!s_r) begin
          gap_s = gap_inc_s;
          if (gap_inc_s >= GAP_C) begin
            state_s = IDLE;
          end else begin
            state_s = ARM;
          end
        end else begin
          gap_s = {CNT_W{1'b0}};
        end
      end
      IDLE: begin
        if (s_r) begin
          width_s = CNT_ONE;
          state_s = MEAS;
        end else begin
          state_s = IDLE;
        end
      end
      MEAS: begin
        if (s_r) begin
          // Another high cycle would take the width past the jam limit.
          if (width_r >= STUCK_C) begin
            reject_s = 1'b1;
            state_s  = JAM;
          end else begin
            width_s = width_inc_s;
          end
        end else begin
          coin_s   = class_s[2:1];
          reject_s = class_s[0];
          gap_s    = CNT_ONE;
          state_s  = ARM;
        end
      end
      JAM: begin
        if (!s_r) begin
          gap_s   = CNT_ONE;
          state_s = ARM;
        end else begin
          state_s = JAM;
        end
      end
      default: begin
        state_s = ARM;
      end
    endcase
  end

  // Synchroniser, FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      s_r     <= 1'b0;
      state_r <= ARM;
      width_r <= {CNT_W{1'b0}};
      gap_r   <= {CNT_W{1'b0}};
      coin    <= 2'b00;
      reject  <= 1'b0;
    end else begin
      sync1_r <= sensor_in;
      s_r     <= sync1_r;
      state_r <= state_s;
      width_r <= width_s;
      gap_r   <= gap_s;
      coin    <= coin_s;
      reject  <= reject_s;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: pulse widths, latency, jam, enable, rearm, reset.
`timescale 1ns/1ps
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_in = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] coin;
  logic       reject;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int ev_cyc = -1;
  int rej_cyc = -1;
  int n_nick = 0;
  int n_dime = 0;
  int n_rej = 0;
  int n_both = 0;
  int n_code3 = 0;

  coin_acceptor dut (
    .clk       (clk),
    .rst       (rst),
    .sensor_in (sensor_in),
    .enable    (enable),
    .coin      (coin),
    .reject    (reject)
  );

  always #5 clk = ~clk;

  // Output monitor sampled 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (coin == 2'b01) begin n_nick = n_nick + 1; ev_cyc = cyc; end
      if (coin == 2'b10) begin n_dime = n_dime + 1; ev_cyc = cyc; end
      if (coin == 2'b11) n_code3 = n_code3 + 1;
      if (reject) begin n_rej = n_rej + 1; rej_cyc = cyc; end
      if (reject && coin != 2'b00) n_both = n_both + 1;
    end
  end

  task automatic clear_mon();
    n_nick = 0; n_dime = 0; n_rej = 0; ev_cyc = -1; rej_cyc = -1;
  endtask

  task automatic pulse(input int w, input int lows);
    @(negedge clk);
    sensor_in = 1'b1;
    repeat (w) @(negedge clk);
    sensor_in = 1'b0;
    fall_cyc = cyc;
    repeat (lows) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sensor_in = 1'b0; enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (coin !== 2'b00 || reject !== 1'b0) begin
        bad++; $display("FAIL reset_out: coin=%b reject=%b want 00/0", coin, reject);
      end
    end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    total++;
    if (dut.state_r !== 2'd1) begin
      bad++; $display("FAIL reset_idle: state=%0d want 1", dut.state_r);
    end
    clear_mon();
  endtask

  task automatic test_nickel();
    clear_mon(); pulse(6, 8);
    total++;
    if (n_nick != 1 || n_dime != 0 || n_rej != 0) begin
      bad++; $display("FAIL nickel: nick=%0d dime=%0d rej=%0d want 1/0/0", n_nick, n_dime, n_rej);
    end
    total++;
    if (ev_cyc - fall_cyc != 3) begin
      bad++; $display("FAIL nickel_latency: got %0d want 3", ev_cyc - fall_cyc);
    end
  endtask

  task automatic test_dime();
    clear_mon(); pulse(15, 8);
    total++;
    if (n_nick != 0 || n_dime != 1 || n_rej != 0) begin
      bad++; $display("FAIL dime: nick=%0d dime=%0d rej=%0d want 0/1/0", n_nick, n_dime, n_rej);
    end
    total++;
    if (ev_cyc - fall_cyc != 3) begin
      bad++; $display("FAIL dime_latency: got %0d want 3", ev_cyc - fall_cyc);
    end
  endtask

  // Expected: 0 none, 1 nickel, 2 dime, 3 reject.
  task automatic test_widths();
    int widths [12] = '{1, 2, 3, 4, 8, 9, 10, 11, 12, 20, 21, 60};
    int expect_k [12] = '{0, 3, 3, 1, 1, 3, 3, 3, 2, 2, 3, 3};
    for (int i = 0; i < 12; i++) begin
      clear_mon(); pulse(widths[i], 8);
      total++;
      if (n_nick != (expect_k[i] == 1 ? 1 : 0) || n_dime != (expect_k[i] == 2 ? 1 : 0) ||
          n_rej != (expect_k[i] == 3 ? 1 : 0)) begin
        bad++;
        $display("FAIL width_%0d: nick=%0d dime=%0d rej=%0d want kind %0d",
                 widths[i], n_nick, n_dime, n_rej, expect_k[i]);
      end
    end
  endtask

  task automatic test_jam();
    clear_mon(); pulse(70, 8);
    total++;
    if (n_rej != 1 || n_nick != 0 || n_dime != 0) begin
      bad++; $display("FAIL jam: nick=%0d dime=%0d rej=%0d want 0/0/1", n_nick, n_dime, n_rej);
    end
    total++;
    if (rej_cyc != fall_cyc - 7) begin
      bad++; $display("FAIL jam_time: rej_cyc=%0d want %0d", rej_cyc, fall_cyc - 7);
    end
    clear_mon(); pulse(6, 8);
    total++;
    if (n_nick != 1 || n_rej != 0) begin
      bad++; $display("FAIL after_jam: nick=%0d rej=%0d want 1/0", n_nick, n_rej);
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    clear_mon(); pulse(15, 8);
    total++;
    if (n_rej != 1 || n_dime != 0 || n_nick != 0) begin
      bad++; $display("FAIL disabled_dime: dime=%0d rej=%0d want 0/1", n_dime, n_rej);
    end
    enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    clear_mon();
    pulse(6, 0);
    pulse(6, 8);
    total++;
    if (n_nick != 1 || n_rej != 0 || n_dime != 0) begin
      bad++; $display("FAIL back_to_back: nick=%0d rej=%0d want 1/0", n_nick, n_rej);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    @(negedge clk); sensor_in = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    sensor_in = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (n_nick != 0 || n_dime != 0 || n_rej != 0) begin
      bad++; $display("FAIL reset_mid: nick=%0d dime=%0d rej=%0d want 0/0/0", n_nick, n_dime, n_rej);
    end
    clear_mon(); pulse(15, 8);
    total++;
    if (n_dime != 1 || n_rej != 0) begin
      bad++; $display("FAIL dime_after_reset: dime=%0d rej=%0d want 1/0", n_dime, n_rej);
    end
  endtask

  initial begin
    test_reset();
    test_nickel();
    test_dime();
    test_widths();
    test_jam();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (n_both != 0 || n_code3 != 0) begin
      bad++; $display("FAIL exclusive: both=%0d code11=%0d want 0/0", n_both, n_code3);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
